vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_axis_counter.sv | 46 ++++
 rtl/vga_timing_gen.sv | 180 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types, reset timing and helpers for the VGA timing generator.
package vga_pkg;

    localparam int unsigned VGA_X_W   = 12;
    localparam int unsigned VGA_Y_W   = 11;
    localparam int unsigned VGA_DIV_W = 4;

    // One complete timing description; loaded through the config port.
    typedef struct packed {
        logic [VGA_X_W-1:0]   h_res;
        logic [VGA_X_W-1:0]   h_fp;
        logic [VGA_X_W-1:0]   h_sync;
        logic [VGA_X_W-1:0]   h_bp;
        logic [VGA_Y_W-1:0]   v_res;
        logic [VGA_Y_W-1:0]   v_fp;
        logic [VGA_Y_W-1:0]   v_sync;
        logic [VGA_Y_W-1:0]   v_bp;
        logic [VGA_DIV_W-1:0] div;
        logic                 h_pol;
        logic                 v_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480 = '{
        h_res: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
        v_res: 11'd480, v_fp: 11'd10, v_sync: 11'd2,  v_bp: 11'd33,
        div: 4'd1, h_pol: 1'b0, v_pol: 1'b0
    };

    // Pixels per line, at the horizontal field width.
    function automatic logic [VGA_X_W-1:0] h_total(input vga_timing_t t);
        return t.h_res + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    // Lines per frame, at the vertical field width.
    function automatic logic [VGA_Y_W-1:0] v_total(input vga_timing_t t);
        return t.v_res + t.v_fp + t.v_sync + t.v_bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counts active, front porch, sync, back porch and wraps.
module vga_axis_counter #(
    parameter int unsigned W = 12
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         advance,
    input  logic [W-1:0] res,
    input  logic [W-1:0] fp,
    input  logic [W-1:0] sync,
    input  logic [W-1:0] bp,
    input  logic         pol,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         sync_lvl,
    output logic         active
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] sync_lo;
    logic [W-1:0] sync_hi;
    logic [W-1:0] last;
    logic         at_last;
    logic         in_sync;

    assign sync_lo = res + fp;
    assign sync_hi = sync_lo + sync;
    assign last    = sync_hi + bp - W'(1);
    assign at_last = (cnt_q == last);
    assign in_sync = (cnt_q >= sync_lo) && (cnt_q < sync_hi);

    // Position counter, steps once per advance and wraps after the back porch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (advance) begin
            cnt_q <= at_last ? '0 : cnt_q + W'(1);
        end
    end

    assign cnt      = cnt_q;
    assign wrap     = advance && at_last;
    assign sync_lvl = in_sync ? pol : ~pol;
    assign active   = (cnt_q < res);

endmodule

// File: rtl/vga_timing_gen.sv
// Runtime-configurable VGA timing generator with frame-aligned config apply.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned X_POS_W    = VGA_X_W,
    parameter int unsigned Y_POS_W    = VGA_Y_W,
    parameter int unsigned DIV_W      = VGA_DIV_W,
    parameter int unsigned SYNC_DELAY = 0,
    parameter vga_timing_t RESET_CFG  = VGA_640X480
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  vga_timing_t        cfg_i,
    output logic               pixel_en_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic [X_POS_W-1:0] pixel_x_o,
    output logic [Y_POS_W-1:0] pixel_y_o,
    output logic               visible_range_o,
    output logic               line_start_o,
    output logic               frame_start_o
);

    // {hsync, vsync, visible} while idle: syncs deasserted, outside active area.
    localparam logic [2:0] SYNC_IDLE = {~RESET_CFG.h_pol, ~RESET_CFG.v_pol, 1'b0};

    vga_timing_t        act_q;
    vga_timing_t        shd_q;
    logic               shd_full_q;
    logic               cfg_ready_q;
    logic [DIV_W-1:0]   div_cnt_q;
    logic               pixel_en;
    logic               cfg_accept;
    logic               apply;

    logic [X_POS_W-1:0] h_cnt;
    logic [Y_POS_W-1:0] v_cnt;
    logic               h_wrap;
    logic               v_wrap;
    logic               h_sync_lvl;
    logic               v_sync_lvl;
    logic               h_active;
    logic               v_active;

    logic [2:0]         sync_raw;
    logic [2:0]         sync_dly;
    logic [2:0]         sync_q;
    logic               pixel_en_q;
    logic [X_POS_W-1:0] pixel_x_q;
    logic [Y_POS_W-1:0] pixel_y_q;
    logic               line_start_q;
    logic               frame_start_q;

    assign pixel_en   = (div_cnt_q == DIV_W'(act_q.div));
    assign cfg_accept = cfg_valid_i && cfg_ready_q;
    assign apply      = v_wrap;

    // Clock divider producing the one-clock pixel enable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
        end else if (pixel_en) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    // Shadow register and handshake; a word arriving on the apply cycle bypasses the shadow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_q       <= RESET_CFG;
            shd_q       <= '0;
            shd_full_q  <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else if (cfg_accept) begin
            if (apply) begin
                act_q <= cfg_i;
            end else begin
                shd_q      <= cfg_i;
                shd_full_q <= 1'b1;
            end
            cfg_ready_q <= 1'b0;
        end else if (apply && shd_full_q) begin
            act_q       <= shd_q;
            shd_full_q  <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else if (!cfg_ready_q && !shd_full_q) begin
            cfg_ready_q <= 1'b1;
        end
    end

    vga_axis_counter #(.W(X_POS_W)) u_h_axis (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .advance  (pixel_en),
        .res      (X_POS_W'(act_q.h_res)),
        .fp       (X_POS_W'(act_q.h_fp)),
        .sync     (X_POS_W'(act_q.h_sync)),
        .bp       (X_POS_W'(act_q.h_bp)),
        .pol      (act_q.h_pol),
        .cnt      (h_cnt),
        .wrap     (h_wrap),
        .sync_lvl (h_sync_lvl),
        .active   (h_active)
    );

    vga_axis_counter #(.W(Y_POS_W)) u_v_axis (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .advance  (h_wrap),
        .res      (Y_POS_W'(act_q.v_res)),
        .fp       (Y_POS_W'(act_q.v_fp)),
        .sync     (Y_POS_W'(act_q.v_sync)),
        .bp       (Y_POS_W'(act_q.v_bp)),
        .pol      (act_q.v_pol),
        .cnt      (v_cnt),
        .wrap     (v_wrap),
        .sync_lvl (v_sync_lvl),
        .active   (v_active)
    );

    assign sync_raw = {h_sync_lvl, v_sync_lvl, h_active && v_active};

    generate
        if (SYNC_DELAY == 0) begin : g_no_dly
            assign sync_dly = sync_raw;
        end else begin : g_dly
            logic [SYNC_DELAY-1:0][2:0] dly_q;

            // Pixel-enable delay line aligning syncs with downstream pixel latency.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    dly_q <= {SYNC_DELAY{SYNC_IDLE}};
                end else if (pixel_en) begin
                    dly_q[0] <= sync_raw;
                    for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign sync_dly = dly_q[SYNC_DELAY-1];
        end
    endgenerate

    // Output registers, updated on pixel-enable clocks; strobes last one clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pixel_en_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            sync_q        <= SYNC_IDLE;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pixel_en_q    <= pixel_en;
            line_start_q  <= pixel_en && (h_cnt == '0);
            frame_start_q <= pixel_en && (h_cnt == '0) && (v_cnt == '0);
            if (pixel_en) begin
                pixel_x_q <= h_cnt;
                pixel_y_q <= v_cnt;
                sync_q    <= sync_dly;
            end
        end
    end

    assign cfg_ready_o     = cfg_ready_q;
    assign pixel_en_o      = pixel_en_q;
    assign pixel_x_o       = pixel_x_q;
    assign pixel_y_o       = pixel_y_q;
    assign hsync_o         = sync_q[2];
    assign vsync_o         = sync_q[1];
    assign visible_range_o = sync_q[0];
    assign line_start_o    = line_start_q;
    assign frame_start_o   = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: dut_a uses all defaults, dut_b a small reset mode with SYNC_DELAY = 2.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam vga_timing_t CFG_R0 = '{
        h_res: 12'd6, h_fp: 12'd1, h_sync: 12'd2, h_bp: 12'd1,
        v_res: 11'd3, v_fp: 11'd1, v_sync: 11'd1, v_bp: 11'd1,
        div: 4'd1, h_pol: 1'b0, v_pol: 1'b0};
    localparam vga_timing_t CFG_A = '{
        h_res: 12'd8, h_fp: 12'd2, h_sync: 12'd3, h_bp: 12'd2,
        v_res: 11'd4, v_fp: 11'd1, v_sync: 11'd2, v_bp: 11'd1,
        div: 4'd0, h_pol: 1'b1, v_pol: 1'b1};
    localparam vga_timing_t CFG_B = '{
        h_res: 12'd4, h_fp: 12'd1, h_sync: 12'd1, h_bp: 12'd1,
        v_res: 11'd2, v_fp: 11'd1, v_sync: 11'd1, v_bp: 11'd1,
        div: 4'd0, h_pol: 1'b1, v_pol: 1'b0};
    localparam vga_timing_t CFG_C = '{
        h_res: 12'd3, h_fp: 12'd1, h_sync: 12'd1, h_bp: 12'd1,
        v_res: 11'd2, v_fp: 11'd1, v_sync: 11'd1, v_bp: 11'd1,
        div: 4'd2, h_pol: 1'b0, v_pol: 1'b1};
    localparam int unsigned DLY_B = 2;

    typedef struct packed {
        logic [27:0] word;
        logic [7:0]  gap;
    } exp_t;

    logic clk;
    logic rst_a, rst_b;
    logic valid_a, valid_b, ready_a, ready_b;
    vga_timing_t cfg_a, cfg_b;
    logic pe_a, hs_a, vs_a, vis_a, ls_a, fs_a;
    logic pe_b, hs_b, vs_b, vis_b, ls_b, fs_b;
    logic [11:0] x_a, x_b;
    logic [10:0] y_a, y_b;

    exp_t       q_a[$], q_b[$];
    logic [2:0] hist_a[$], hist_b[$];
    exp_t       ea, eb;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         last_a = 0, last_b = 0;
    int         fs_cnt_b = 0;
    int         fs_cyc_b[16];

    vga_timing_gen u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .cfg_valid_i(valid_a), .cfg_ready_o(ready_a),
        .cfg_i(cfg_a), .pixel_en_o(pe_a), .hsync_o(hs_a), .vsync_o(vs_a),
        .pixel_x_o(x_a), .pixel_y_o(y_a), .visible_range_o(vis_a),
        .line_start_o(ls_a), .frame_start_o(fs_a)
    );

    vga_timing_gen #(.SYNC_DELAY(DLY_B), .RESET_CFG(CFG_R0)) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .cfg_valid_i(valid_b), .cfg_ready_o(ready_b),
        .cfg_i(cfg_b), .pixel_en_o(pe_b), .hsync_o(hs_b), .vsync_o(vs_b),
        .pixel_x_o(x_b), .pixel_y_o(y_b), .visible_range_o(vis_b),
        .line_start_o(ls_b), .frame_start_o(fs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected output stream for nlines of a mode; syncs delayed through a history queue.
    task automatic gen_frame(input bit to_b, input vga_timing_t t, input int nlines, input bit skip_gap);
        int ht, hr, hs0, hs1, vr, vs0, vs1;
        logic hs, vs, vis;
        logic [2:0] raw, del;
        exp_t e;
        ht  = int'(h_total(t));
        hr  = int'(t.h_res);
        hs0 = hr + int'(t.h_fp);
        hs1 = hs0 + int'(t.h_sync);
        vr  = int'(t.v_res);
        vs0 = vr + int'(t.v_fp);
        vs1 = vs0 + int'(t.v_sync);
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < ht; x++) begin
                hs  = (x >= hs0 && x < hs1) ? t.h_pol : ~t.h_pol;
                vs  = (y >= vs0 && y < vs1) ? t.v_pol : ~t.v_pol;
                vis = (x < hr) && (y < vr);
                raw = {hs, vs, vis};
                if (to_b) begin
                    hist_b.push_back(raw);
                    del = hist_b.pop_front();
                end else begin
                    hist_a.push_back(raw);
                    del = hist_a.pop_front();
                end
                e.word = {12'(x), 11'(y), del, (x == 0), (x == 0) && (y == 0)};
                e.gap  = (skip_gap && x == 0 && y == 0) ? 8'd0 : 8'(int'(t.div) + 1);
                if (to_b) q_b.push_back(e);
                else      q_a.push_back(e);
            end
        end
    endtask

    // dut_a monitor: pops one expectation per pixel enable.
    always @(negedge clk) begin
        if (!rst_a) begin
            if (pe_a) begin
                if (q_a.size() > 0) begin
                    ea = q_a.pop_front();
                    check("a_pixel", 32'({x_a, y_a, hs_a, vs_a, vis_a, ls_a, fs_a}), 32'(ea.word));
                    if (ea.gap != 0) check("a_pe_gap", 32'(cyc - last_a), 32'(ea.gap));
                end
                last_a = cyc;
            end else begin
                check("a_strobe_idle", 32'({ls_a, fs_a}), 32'd0);
            end
        end
    end

    // dut_b monitor: same, plus frame-start bookkeeping.
    always @(negedge clk) begin
        if (!rst_b) begin
            if (pe_b) begin
                if (q_b.size() > 0) begin
                    eb = q_b.pop_front();
                    check("b_pixel", 32'({x_b, y_b, hs_b, vs_b, vis_b, ls_b, fs_b}), 32'(eb.word));
                    if (eb.gap != 0) check("b_pe_gap", 32'(cyc - last_b), 32'(eb.gap));
                end else begin
                    check("b_unexpected_pixel", 32'(q_b.size()), 32'd1);
                end
                if (fs_b && fs_cnt_b < 15) begin
                    fs_cnt_b++;
                    fs_cyc_b[fs_cnt_b] = cyc;
                end
                last_b = cyc;
            end else begin
                check("b_strobe_idle", 32'({ls_b, fs_b}), 32'd0);
            end
        end
    end

    task automatic drain(input bit is_b, input int budget);
        int n;
        n = 0;
        while (((is_b ? q_b.size() : q_a.size()) != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(is_b ? "b_drain" : "a_drain", 32'(is_b ? q_b.size() : q_a.size()), 32'd0);
    endtask

    localparam logic [29:0] RST_OUTS = {12'd0, 11'd0, 7'b0110001};

    initial begin
        int n;
        rst_a = 1'b1; rst_b = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        cfg_a = VGA_640X480; cfg_b = CFG_R0;
        for (int i = 0; i < int'(DLY_B); i++) hist_b.push_back(3'b110);
        repeat (3) @(negedge clk);
        check("a_reset_outs", 32'({x_a, y_a, pe_a, hs_a, vs_a, vis_a, ls_a, fs_a, ready_a}), 32'(RST_OUTS));
        check("b_reset_outs", 32'({x_b, y_b, pe_b, hs_b, vs_b, vis_b, ls_b, fs_b, ready_b}), 32'(RST_OUTS));

        // Default 640x480 timing: two full lines.
        gen_frame(1'b0, VGA_640X480, 2, 1'b1);
        rst_a = 1'b0;
        drain(1'b0, 4000);

        // Async reset mid-line while a config is pending.
        valid_a = 1'b1; cfg_a = CFG_A;
        @(negedge clk);
        valid_a = 1'b0;
        check("a_ready_pending", 32'(ready_a), 32'd0);
        @(posedge clk);
        #3 rst_a = 1'b1;
        #1 check("a_async_reset_outs", 32'({x_a, y_a, pe_a, hs_a, vs_a, vis_a, ls_a, fs_a, ready_a}), 32'(RST_OUTS));
        hist_a.delete();
        gen_frame(1'b0, VGA_640X480, 1, 1'b1);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        drain(1'b0, 2000);
        check("a_ready_after_reset", 32'(ready_a), 32'd1);

        // dut_b: reset mode frame, then reconfigure mid-frame with back-pressure.
        gen_frame(1'b1, CFG_R0, 6, 1'b1);
        rst_b = 1'b0;
        repeat (20) @(negedge clk);
        valid_b = 1'b1; cfg_b = CFG_A;
        @(negedge clk);
        cfg_b = CFG_B;
        check("b_ready_drop", 32'(ready_b), 32'd0);
        gen_frame(1'b1, CFG_A, 8, 1'b0);
        repeat (30) @(negedge clk);
        check("b_ready_held", 32'(ready_b), 32'd0);
        n = 0;
        while (!ready_b && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("b_ready_rise", 32'(ready_b), 32'd1);
        check("b_ready_at_frame_end", 32'(fs_cnt_b), 32'd1);
        @(negedge clk);
        valid_b = 1'b0;
        check("b_second_accepted", 32'(ready_b), 32'd0);
        gen_frame(1'b1, CFG_B, 5, 1'b0);
        gen_frame(1'b1, CFG_B, 5, 1'b0);

        // Word offered exactly on the apply cycle of the second tiny frame.
        n = 0;
        while (fs_cnt_b < 4 && n < 400) begin
            @(negedge clk);
            #1 n++;
        end
        check("b_fs_wait", 32'(fs_cnt_b), 32'd4);
        repeat (33) @(posedge clk);
        @(negedge clk);
        valid_b = 1'b1; cfg_b = CFG_C;
        gen_frame(1'b1, CFG_C, 5, 1'b0);
        gen_frame(1'b1, CFG_C, 5, 1'b0);
        @(negedge clk);
        valid_b = 1'b0;
        check("b_bypass_ready_low", 32'(ready_b), 32'd0);
        @(negedge clk);
        check("b_bypass_ready_back", 32'(ready_b), 32'd1);
        drain(1'b1, 600);
        check("b_tiny_frame_period", 32'(fs_cyc_b[4] - fs_cyc_b[3]), 32'd35);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
